ram_loader: RTL

Serial boot loader that writes program images into the 32-bit read/write port of the 8192×32 code/data RAM. It consumes a framed byte stream from the UART receiver over a valid/ready handshake, assembles little-endian 32-bit words and writes them to consecutive word addresses starting at byte address 0. It holds `busy` high for the whole frame so the top level keeps the J1 core in reset while it loads. It is the writer at the far end of the instruction fetch path.

---
 rtl/ram_loader_if.sv | 24 ++
 rtl/ram_loader.sv | 109 ++++++++++
 2 files changed

// File: rtl/ram_loader_if.sv
// Byte-stream input and RAM port-a write side of the serial boot loader.
interface ram_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_addr;
  logic [31:0] a_d;
  logic        a_wr;
  logic        busy;
  logic        done;
  logic        err;

  // Loader side
  modport slave (
    input  in_data, in_valid,
    output in_ready, a_addr, a_d, a_wr, busy, done, err
  );

  // Byte source / RAM / status observer side
  modport master (
    output in_data, in_valid,
    input  in_ready, a_addr, a_d, a_wr, busy, done, err
  );
endinterface

// File: rtl/ram_loader.sv
// Serial boot loader: parses A5/count/data/checksum frames from a byte
// stream and writes little-endian words to consecutive RAM word addresses.
module ram_loader #(
  parameter int WORDS = 8192
) (
  input  logic         clk,
  input  logic         resetq,
  ram_loader_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, SUM} state_t;

  state_t      state, state_nx;
  logic [7:0]  cnt_lo;
  logic [15:0] count;
  logic [13:0] idx;
  logic [1:0]  bcnt;
  logic [23:0] wd;      // lanes 0..2; lane 3 goes straight to a_d
  logic [7:0]  sum;
  logic        acc;
  logic [15:0] len_in;
  logic        len_big;
  logic        last_word;

  // WRITE is the only cycle that refuses a byte
  assign bus.in_ready = resetq && (state != WRITE);
  assign acc          = bus.in_valid && bus.in_ready;
  assign bus.busy     = (state != IDLE);
  assign len_in       = {bus.in_data, cnt_lo};
  assign len_big      = {1'b0, len_in} > 17'(WORDS);
  assign last_word    = ({2'b00, idx} + 16'd1) == count;

  // State register
  always_ff @(posedge clk) begin
    if (!resetq) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state logic: advance on accepted bytes, WRITE always advances
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (acc && bus.in_data == 8'hA5) state_nx = LEN0;
      LEN0:    if (acc) state_nx = LEN1;
      LEN1:    if (acc) begin
                 if (len_big)             state_nx = IDLE;
                 else if (len_in == '0)   state_nx = SUM;
                 else                     state_nx = DATA;
               end
      DATA:    if (acc && bcnt == 2'd3) state_nx = WRITE;
      WRITE:   state_nx = last_word ? SUM : DATA;
      SUM:     if (acc) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: word assembly, checksum, registered RAM strobe and status
  always_ff @(posedge clk) begin
    if (!resetq) begin
      cnt_lo     <= '0;
      count      <= '0;
      idx        <= '0;
      bcnt       <= '0;
      wd         <= '0;
      sum        <= '0;
      bus.a_wr   <= 1'b0;
      bus.a_addr <= '0;
      bus.a_d    <= '0;
      bus.done   <= 1'b0;
      bus.err    <= 1'b0;
    end else begin
      bus.a_wr <= 1'b0;
      bus.done <= 1'b0;
      case (state)
        IDLE: if (acc && bus.in_data == 8'hA5) begin
          bus.err <= 1'b0;
          sum     <= '0;
          idx     <= '0;
          bcnt    <= '0;
        end
        LEN0: if (acc) cnt_lo <= bus.in_data;
        LEN1: if (acc) begin
          count <= len_in;
          if (len_big) bus.err <= 1'b1;
        end
        DATA: if (acc) begin
          sum  <= sum + bus.in_data;
          bcnt <= bcnt + 2'd1;
          case (bcnt)
            2'd0: wd[7:0]   <= bus.in_data;
            2'd1: wd[15:8]  <= bus.in_data;
            2'd2: wd[23:16] <= bus.in_data;
            default: begin
              // 4th byte: strobe lands in the WRITE cycle
              bus.a_wr   <= 1'b1;
              bus.a_addr <= {idx, 2'b00};
              bus.a_d    <= {bus.in_data, wd};
            end
          endcase
        end
        WRITE: idx <= idx + 14'd1;
        SUM: if (acc) begin
          if (bus.in_data == sum) bus.done <= 1'b1;
          else                    bus.err  <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
